// File: rtl/display_scan_ctrl.sv
// Two-digit multiplexed 7-segment scan controller with a debounced Gray-code input.
// The external decoder turns gray_stable/show_decades into seg_in, and this block drives the segment bus and digit enables.
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter int unsigned DEB_CYC   = 100000,
  parameter bit          LZ_BLANK  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] gray_code,
  input  logic [6:0] seg_in,
  output logic [3:0] gray_stable,
  output logic       show_decades,
  output logic [6:0] seg_out,
  output logic [1:0] an,
  output logic       code_valid
);

  localparam int unsigned SLOT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned SLOT_W   = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
  localparam int unsigned DEB_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  typedef enum logic [1:0] {BLANK_U, UNITS, BLANK_D, DECADES} state_e;

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [3:0]        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]        gray_stable_q, gray_stable_d;
  logic [1:0]        an_q, an_d;
  logic [6:0]        seg_out_q, seg_out_d;
  logic              code_valid_q, code_valid_d;

  logic [3:0] bin_c;
  logic       tens_nz;
  logic       deb_inc;
  logic       slot_last;

  // Gray-to-binary of the accepted code; only the tens test needs it.
  always_comb begin
    bin_c[3] = gray_stable_q[3];
    bin_c[2] = ^gray_stable_q[3:2];
    bin_c[1] = ^gray_stable_q[3:1];
    bin_c[0] = ^gray_stable_q[3:0];
    tens_nz  = (bin_c >= 4'd10);
  end

  always_comb begin
    sync1_d       = gray_code;
    sync2_d       = sync1_q;
    deb_cnt_d     = '0;
    gray_stable_d = gray_stable_q;
    code_valid_d  = 1'b0;
    state_d       = state_q;
    slot_cnt_d    = slot_cnt_q + SLOT_W'(1);
    an_d          = 2'b11;
    seg_out_d     = seg_in;

    // sync1 is the value sync2 takes next, so equality means sync2 holds steady.
    deb_inc = (sync1_q == sync2_q) && (sync2_q != gray_stable_q);
    if (deb_inc) begin
      if (deb_cnt_q == DEB_W'(DEB_CYC - 1)) begin
        gray_stable_d = sync2_q;
        code_valid_d  = 1'b1;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end

    if ((state_q == BLANK_U) || (state_q == BLANK_D)) begin
      slot_last = (slot_cnt_q == SLOT_W'(BLANK_CYC - 1));
    end else begin
      slot_last = (slot_cnt_q == SLOT_W'(SCAN_DIV - 1));
    end

    if (slot_last) begin
      slot_cnt_d = '0;
      case (state_q)
        BLANK_U: state_d = UNITS;
        UNITS:   state_d = BLANK_D;
        BLANK_D: state_d = DECADES;
        default: state_d = BLANK_U;
      endcase
    end

    // Enables follow the current state one cycle later, in step with seg_out.
    case (state_q)
      UNITS:   an_d = 2'b10;
      DECADES: an_d = (LZ_BLANK && !tens_nz) ? 2'b11 : 2'b01;
      default: an_d = 2'b11;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BLANK_U;
      slot_cnt_q    <= '0;
      deb_cnt_q     <= '0;
      sync1_q       <= 4'b0000;
      sync2_q       <= 4'b0000;
      gray_stable_q <= 4'b0000;
      an_q          <= 2'b11;
      seg_out_q     <= 7'h00;
      code_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_cnt_q    <= slot_cnt_d;
      deb_cnt_q     <= deb_cnt_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      gray_stable_q <= gray_stable_d;
      an_q          <= an_d;
      seg_out_q     <= seg_out_d;
      code_valid_q  <= code_valid_d;
    end
  end

  // The decoder gets the tens select through the blank gap so it settles early.
  assign show_decades = (state_q == BLANK_D) || (state_q == DECADES);
  assign gray_stable  = gray_stable_q;
  assign seg_out      = seg_out_q;
  assign an           = an_q;
  assign code_valid   = code_valid_q;

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-high reset, rst.
REQ-002 Parameter SCAN_DIV, default 50000, SHALL set the clk cycles per lit digit slot (legal range >=2).
REQ-003 Parameter BLANK_CYC, default 500, SHALL set the clk cycles of the all-off gap before each slot (legal range >=1).
REQ-004 Parameter DEB_CYC, default 100000, SHALL set the clk cycles a synchronized input must stay stable before it is accepted (legal range >=1).
REQ-005 Parameter LZ_BLANK, default 1, SHALL enable suppression of a leading-zero tens digit when set to 1.
REQ-006 Port clk, input, 1 bit, SHALL be the system clock, rising edge.
REQ-007 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-008 Port gray_code, input, 4 bits, SHALL carry the raw asynchronous Gray-code switch value.
REQ-009 Port seg_in, input, 7 bits, SHALL carry the segment pattern returned by the Gray-to-7-segment decoder.
REQ-010 Port gray_stable, output, 4 bits, SHALL carry the debounced Gray code that drives the decoder's gray_code input.
REQ-011 Port show_decades, output, 1 bit, SHALL drive the decoder's show_decades select: 1 selects the tens digit, 0 selects the units digit.
REQ-012 Port seg_out, output, 7 bits, SHALL drive the shared segment bus.
REQ-013 Port an, output, 2 bits, SHALL drive the active-low digit enables: an[0] enables units, an[1] enables tens.
REQ-014 Port code_valid, output, 1 bit, SHALL pulse for one cycle when gray_stable changes.

Function
REQ-015 Input synchronization SHALL use a 2-flop synchronizer sync1 -> sync2 on gray_code.
REQ-016 Debounce: deb_cnt SHALL increment when sync2 equals its previous-cycle value and differs from gray_stable, and SHALL clear to 0 otherwise.
REQ-017 On a cycle where the increment condition holds and deb_cnt equals DEB_CYC-1, the block SHALL load gray_stable from sync2, pulse code_valid=1, and clear deb_cnt; total latency from a gray_code edge to gray_stable is DEB_CYC+2 cycles.
REQ-018 The scan FSM SHALL use states BLANK_U, UNITS, BLANK_D, DECADES, visited in the order BLANK_U -> UNITS -> BLANK_D -> DECADES -> BLANK_U.
REQ-019 BLANK states SHALL last BLANK_CYC cycles, lit states SHALL last SCAN_DIV cycles, and the scan period SHALL be 2*(SCAN_DIV+BLANK_CYC).
REQ-020 The slot counter SHALL count 0..length-1, and the state SHALL advance on the cycle it holds length-1, with the counter wrapping to 0.
REQ-021 show_decades SHALL be a combinational function of state: 1 in BLANK_D and DECADES, 0 in BLANK_U and UNITS, so that the decoder settles during the gap.
REQ-022 tens_nz SHALL be 1 when the binary value of gray_stable (b3=g3, bi=b(i+1)^gi) is >= 10.
REQ-023 an SHALL be a registered output with next value 2'b10 in UNITS, 2'b01 in DECADES, and 2'b11 in BLANK states.
REQ-024 In DECADES, next an SHALL be 2'b11 when LZ_BLANK=1 and tens_nz=0.
REQ-025 seg_out SHALL be a registered output whose next value is seg_in every cycle, so that seg_out and an share a one-cycle latency.
REQ-026 When gray_stable changes mid-slot, the new value SHALL take effect through seg_in without restarting the scan.
REQ-027 an SHALL never hold 2'b00.
REQ-028 Between any two different lit digits, an SHALL hold 2'b11 for at least BLANK_CYC cycles.

Reset
REQ-029 While rst=1 at a clk edge, the block SHALL set state=BLANK_U, slot counter=0, deb_cnt=0, sync1=sync2=0, gray_stable=4'b0000, an=2'b11, seg_out=7'h00, code_valid=0.
REQ-030 The first post-reset scan SHALL begin at BLANK_U, cycle 0.
REQ-031 A reset asserted mid-slot or mid-debounce SHALL abort the operation with no partial gray_stable update.

Verification (SCAN_DIV=4, BLANK_CYC=2, DEB_CYC=4 unless noted)
REQ-032 Reset check: hold rst for 3 cycles -> an=11, seg_out=00, show_decades=0, gray_stable=0000, code_valid=0.
REQ-033 Scan timing: gray_stable=1000 (15) -> repeating an pattern 11 x2, 10 x4, 11 x2, 01 x4 with a 12-cycle period, and show_decades high for 6 of every 12 cycles.
REQ-034 Debounce accept: gray_code 0000 -> 1101 held -> gray_stable=1101 exactly 6 cycles after the edge, with code_valid high for exactly 1 cycle.
REQ-035 Glitch reject: gray_code 0000 -> 0110 for 3 cycles, then back to 0000 -> gray_stable stays 0000 and code_valid stays 0.
REQ-036 Leading zero: gray_stable=0111 (5) -> with LZ_BLANK=1, an is never 01; with LZ_BLANK=0, an=01 for 4 cycles per period.
REQ-037 Reset mid-slot: assert rst during UNITS -> an=11 on the next cycle, and after release BLANK_U lasts 2 cycles before an=10.
